// File: rtl/ahb_interconnect_n.sv
// Single-master AHB interconnect for NUM_SLAVES slaves: address decoder, data-phase
// response mux, built-in default slave (two-cycle ERROR) and a saturating decode-error counter.
module ahb_interconnect_n #(
    parameter int NUM_SLAVES = 4,
    parameter int SEL_W      = 2,
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int ERRCNT_W   = 16
) (
    input  logic                         hclk,
    input  logic                         hreset,
    input  logic [ADDR_W-1:0]            haddr,
    input  logic [1:0]                   htrans,
    output logic [NUM_SLAVES-1:0]        hsel,
    input  logic [NUM_SLAVES*DATA_W-1:0] hrdata_s,
    input  logic [NUM_SLAVES-1:0]        hreadyout_s,
    input  logic [NUM_SLAVES-1:0]        hresp_s,
    output logic [DATA_W-1:0]            hrdata,
    output logic                         hready,
    output logic                         hresp,
    input  logic                         err_clr,
    output logic [ERRCNT_W-1:0]          err_count
);

    localparam int NUM_IDX = 2**SEL_W;
    localparam logic [SEL_W:0] NUM_SLAVES_W = (SEL_W+1)'(NUM_SLAVES);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ERR1,
        S_ERR2
    } state_t;

    logic [SEL_W-1:0]    w_idx;
    logic                w_mapped;
    logic                w_own;
    logic                w_err_start;
    logic                w_unused_addr;
    logic [DATA_W-1:0]   w_rdata_tab [NUM_IDX];
    logic                w_ready_tab [NUM_IDX];
    logic                w_resp_tab  [NUM_IDX];

    logic [SEL_W-1:0]    r_dsel;
    logic                r_dvalid;
    logic                r_dmapped;
    state_t              r_state;
    logic                r_def_ready;
    logic                r_def_resp;
    logic [ERRCNT_W-1:0] r_err_count;

    assign w_idx         = haddr[ADDR_W-1 -: SEL_W];
    assign w_mapped      = ({1'b0, w_idx} < NUM_SLAVES_W);
    assign w_unused_addr = ^{haddr[ADDR_W-SEL_W-1:0], htrans[0]};

    // Response tables padded to the full index space so r_dsel never indexes out of range.
    generate
        for (genvar gi = 0; gi < NUM_IDX; gi++) begin : g_tab
            if (gi < NUM_SLAVES) begin : g_mapped
                assign hsel[gi]        = (w_idx == SEL_W'(gi));
                assign w_rdata_tab[gi] = hrdata_s[gi*DATA_W +: DATA_W];
                assign w_ready_tab[gi] = hreadyout_s[gi];
                assign w_resp_tab[gi]  = hresp_s[gi];
            end else begin : g_unmapped
                assign w_rdata_tab[gi] = '0;
                assign w_ready_tab[gi] = 1'b1;
                assign w_resp_tab[gi]  = 1'b0;
            end
        end
    endgenerate

    assign w_own  = r_dvalid & r_dmapped;
    assign hrdata = w_own ? w_rdata_tab[r_dsel] : '0;
    assign hready = w_own ? w_ready_tab[r_dsel] : r_def_ready;
    assign hresp  = w_own ? w_resp_tab[r_dsel]  : r_def_resp;

    assign w_err_start = hready & htrans[1] & ~w_mapped;
    assign err_count   = r_err_count;

    always_ff @(posedge hclk) begin
        if (hreset) begin
            r_dsel    <= '0;
            r_dvalid  <= 1'b0;
            r_dmapped <= 1'b0;
        end else if (hready) begin
            r_dsel    <= w_idx;
            r_dvalid  <= htrans[1];
            r_dmapped <= w_mapped;
        end
    end

    // ERR2 drives hready high, so it evaluates the next address exactly like IDLE.
    always_ff @(posedge hclk) begin
        if (hreset) begin
            r_state     <= S_IDLE;
            r_def_ready <= 1'b1;
            r_def_resp  <= 1'b0;
        end else begin
            case (r_state)
                S_ERR1: begin
                    r_state     <= S_ERR2;
                    r_def_ready <= 1'b1;
                    r_def_resp  <= 1'b1;
                end
                default: begin
                    if (w_err_start) begin
                        r_state     <= S_ERR1;
                        r_def_ready <= 1'b0;
                        r_def_resp  <= 1'b1;
                    end else begin
                        r_state     <= S_IDLE;
                        r_def_ready <= 1'b1;
                        r_def_resp  <= 1'b0;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge hclk) begin
        if (hreset || err_clr) begin
            r_err_count <= '0;
        end else if (w_err_start && (r_err_count != '1)) begin
            r_err_count <= r_err_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_ahb_interconnect_n.sv
// Bench for ahb_interconnect_n (3 slaves, 4-bit error counter): directed steps then
// randomized traffic, compared each cycle against a transaction-level reference model.
module tb_ahb_interconnect_n;

    localparam int NS   = 3;
    localparam int ERRW = 4;
    localparam int CMAX = (1 << ERRW) - 1;

    logic            clk = 1'b0;
    logic            hreset;
    logic [31:0]     haddr;
    logic [1:0]      htrans;
    logic [NS-1:0]   hsel;
    logic [NS*32-1:0] hrdata_s;
    logic [NS-1:0]   hreadyout_s;
    logic [NS-1:0]   hresp_s;
    logic [31:0]     hrdata;
    logic            hready;
    logic            hresp;
    logic            err_clr;
    logic [ERRW-1:0] err_count;

    logic [31:0]     slv_rdata [NS];

    int checks   = 0;
    int failures = 0;

    // Model: the data phase currently owed to the master.
    // kind 0 = nothing to answer, 1 = mapped slave, 2 = unmapped (two-cycle ERROR)
    int m_kind   = 0;
    int m_slave  = 0;
    int m_errcyc = 0;
    int m_cnt    = 0;

    always #5 clk = ~clk;

    always_comb begin
        hrdata_s = '0;
        for (int i = 0; i < NS; i++) hrdata_s[i*32 +: 32] = slv_rdata[i];
    end

    ahb_interconnect_n #(
        .NUM_SLAVES(NS),
        .SEL_W     (2),
        .ADDR_W    (32),
        .DATA_W    (32),
        .ERRCNT_W  (ERRW)
    ) dut (
        .hclk       (clk),
        .hreset     (hreset),
        .haddr      (haddr),
        .htrans     (htrans),
        .hsel       (hsel),
        .hrdata_s   (hrdata_s),
        .hreadyout_s(hreadyout_s),
        .hresp_s    (hresp_s),
        .hrdata     (hrdata),
        .hready     (hready),
        .hresp      (hresp),
        .err_clr    (err_clr),
        .err_count  (err_count)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Called at the falling edge with inputs already driven; returns at the next falling edge.
    task automatic cycle();
        int          idx;
        bit          unm;
        logic [NS-1:0] e_hsel;
        logic        e_ready;
        logic        e_resp;
        logic [31:0] e_rdata;
        int          n_kind, n_slave, n_errcyc, n_cnt;

        #1;
        idx    = int'(haddr[31:30]);
        unm    = (idx >= NS);
        e_hsel = unm ? '0 : NS'(1 << idx);

        if (m_kind == 1) begin
            e_rdata = slv_rdata[m_slave];
            e_ready = hreadyout_s[m_slave];
            e_resp  = hresp_s[m_slave];
        end else if (m_kind == 2) begin
            e_rdata = 32'h0;
            e_ready = (m_errcyc == 1);
            e_resp  = 1'b1;
        end else begin
            e_rdata = 32'h0;
            e_ready = 1'b1;
            e_resp  = 1'b0;
        end

        chk("hsel",   hsel,   e_hsel);
        chk("hready", hready, e_ready);
        chk("hresp",  hresp,  e_resp);
        chk("hrdata", hrdata, e_rdata);
        $display("cyc rst=%b addr=%h trans=%b hsel=%b hready=%b hresp=%b hrdata=%h clr=%b err=%0d",
                 hreset, haddr, htrans, hsel, hready, hresp, hrdata, err_clr, err_count);

        n_kind   = m_kind;
        n_slave  = m_slave;
        n_errcyc = m_errcyc;
        n_cnt    = m_cnt;
        if (hreset) begin
            n_kind   = 0;
            n_slave  = 0;
            n_errcyc = 0;
            n_cnt    = 0;
        end else begin
            if (err_clr)
                n_cnt = 0;
            else if (e_ready && htrans[1] && unm && m_cnt < CMAX)
                n_cnt = m_cnt + 1;

            if (m_kind == 2 && m_errcyc == 0) begin
                n_errcyc = 1;
            end else if (e_ready) begin
                n_kind   = htrans[1] ? (unm ? 2 : 1) : 0;
                n_slave  = idx;
                n_errcyc = 0;
            end
        end

        @(posedge clk);
        m_kind   = n_kind;
        m_slave  = n_slave;
        m_errcyc = n_errcyc;
        m_cnt    = n_cnt;
        @(negedge clk);
        chk("err_count", err_count, m_cnt);
    endtask

    initial begin
        for (int i = 0; i < NS; i++) slv_rdata[i] = 32'h0;
        hreadyout_s = '1;
        hresp_s     = '0;
        haddr       = 32'hC000_0000;
        htrans      = 2'b10;
        err_clr     = 1'b0;
        hreset      = 1'b1;

        // Reset held two cycles with NONSEQ on the bus
        repeat (2) @(posedge clk);
        @(negedge clk);
        hreset       = 1'b0;
        haddr        = 32'h8000_0010;
        htrans       = 2'b10;
        slv_rdata[2] = 32'hCAFE_0002;
        #1;
        chk("rst_hready", hready, 1'b1);
        chk("rst_hresp",  hresp,  1'b0);
        chk("rst_hrdata", hrdata, 32'h0);
        chk("rst_err",    err_count, 4'h0);
        chk("s2_hsel",    hsel, 3'b100);
        cycle();

        // Slave 2 data phase while slave 1 address is presented
        haddr = 32'h4000_0000;
        #1;
        chk("s2_rdata", hrdata, 32'hCAFE_0002);
        chk("s2_ready", hready, 1'b1);
        cycle();

        // Slave 1 inserts three wait states; next address held on the bus
        haddr          = 32'hC000_0000;
        hreadyout_s[1] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("ws_hready", hready, 1'b0);
            cycle();
        end
        hreadyout_s[1] = 1'b1;
        cycle();

        // Unmapped data phase: ERR1 then ERR2
        haddr  = 32'h0000_0000;
        htrans = 2'b00;
        #1;
        chk("err1_ready", hready, 1'b0);
        chk("err1_resp",  hresp,  1'b1);
        chk("unm_err",    err_count, 4'h1);
        cycle();
        #1;
        chk("err2_ready", hready, 1'b1);
        chk("err2_resp",  hresp,  1'b1);
        cycle();

        // Back-to-back unmapped NONSEQ, err_clr on the second ERR1 entry
        haddr  = 32'hC000_0000;
        htrans = 2'b10;
        cycle();
        #1;
        chk("b2b_err1a", {hready, hresp}, 2'b01);
        cycle();
        err_clr = 1'b1;
        #1;
        chk("b2b_err2a", {hready, hresp}, 2'b11);
        cycle();
        err_clr = 1'b0;
        chk("clr_err", err_count, 4'h0);
        #1;
        chk("b2b_err1b", {hready, hresp}, 2'b01);
        cycle();
        htrans = 2'b00;
        #1;
        chk("b2b_err2b", {hready, hresp}, 2'b11);
        cycle();

        // Seventeen unmapped transfers saturate the counter
        htrans = 2'b11;
        repeat (34) cycle();
        htrans = 2'b00;
        chk("sat_err", err_count, 4'hF);
        cycle();

        // Randomized traffic
        for (int n = 0; n < 600; n++) begin
            haddr  = $urandom;
            htrans = 2'($urandom_range(0, 3));
            for (int i = 0; i < NS; i++) begin
                slv_rdata[i]   = $urandom;
                hreadyout_s[i] = ($urandom_range(0, 3) != 0);
                hresp_s[i]     = ($urandom_range(0, 7) == 0);
            end
            err_clr = ($urandom_range(0, 19) == 0);
            hreset  = ($urandom_range(0, 49) == 0);
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
